// File: rtl/cache_set_controller.sv
// Sequencing controller for one 4-way set-associative cache set.
// Probes all ways, picks a hit / empty / LRU victim way, strobes it for one
// cycle, keeps the 2-bit age ordering and returns the byte over a response
// handshake. Every output is a flop so nothing glitches toward the ways.
module cache_set_controller #(
  parameter int ADDRESS_WORD_SIZE = 32,
  parameter int COUNTER_WIDTH     = 16
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDRESS_WORD_SIZE-1:0] req_address,
  input  logic [7:0]                   req_wdata,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [7:0]                   resp_data,
  output logic                         resp_hit,
  output logic [1:0]                   resp_way,
  output logic [ADDRESS_WORD_SIZE-1:0] way_address,
  output logic [7:0]                   way_write_data,
  output logic [3:0]                   way_ready,
  output logic [3:0]                   way_try_read,
  output logic [3:0]                   way_try_write,
  output logic [3:0]                   way_reset_age,
  output logic [3:0]                   way_increment_age,
  input  logic [3:0]                   way_hit,
  input  logic [3:0]                   way_empty,
  input  logic [7:0]                   way_age,
  input  logic [31:0]                  way_data,
  output logic [COUNTER_WIDTH-1:0]     hit_count,
  output logic [COUNTER_WIDTH-1:0]     miss_count,
  output logic                         multi_hit_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PROBE   = 3'd1,
    EVAL    = 3'd2,
    ACCESS  = 3'd3,
    CAPTURE = 3'd4,
    RESP    = 3'd5
  } state_e;

  state_e                       state_q, state_d;
  logic                         req_ready_q, req_ready_d;
  logic                         write_q, write_d;
  logic [ADDRESS_WORD_SIZE-1:0] way_address_q, way_address_d;
  logic [7:0]                   way_write_data_q, way_write_data_d;
  logic [1:0]                   sel_way_q, sel_way_d;
  logic                         sel_hit_q, sel_hit_d;
  logic [3:0]                   way_ready_q, way_ready_d;
  logic [3:0]                   way_try_read_q, way_try_read_d;
  logic [3:0]                   way_try_write_q, way_try_write_d;
  logic [3:0]                   way_reset_age_q, way_reset_age_d;
  logic [3:0]                   way_increment_age_q, way_increment_age_d;
  logic                         resp_valid_q, resp_valid_d;
  logic [7:0]                   resp_data_q, resp_data_d;
  logic                         resp_hit_q, resp_hit_d;
  logic [1:0]                   resp_way_q, resp_way_d;
  logic [COUNTER_WIDTH-1:0]     hit_count_q, hit_count_d;
  logic [COUNTER_WIDTH-1:0]     miss_count_q, miss_count_d;
  logic                         multi_hit_err_q, multi_hit_err_d;

  logic       hit_found, empty_found, multi_hit;
  logic [1:0] hit_idx, empty_idx, oldest_idx, eval_sel;
  logic [1:0] oldest_age, eval_age;
  logic [3:0] eval_onehot, eval_inc;

  // Way selection from the probe results: lowest hit, else lowest empty, else
  // lowest-index oldest. The increment mask is resolved here against the
  // selected way's age so the ACCESS strobes can come straight from flops.
  always_comb begin
    hit_found   = 1'b0;
    hit_idx     = 2'd0;
    empty_found = 1'b0;
    empty_idx   = 2'd0;
    oldest_idx  = 2'd0;
    oldest_age  = way_age[1:0];
    for (int i = 3; i >= 0; i--) begin
      if (way_hit[i]) begin
        hit_found = 1'b1;
        hit_idx   = 2'(i);
      end
      if (way_empty[i]) begin
        empty_found = 1'b1;
        empty_idx   = 2'(i);
      end
    end
    for (int i = 1; i < 4; i++) begin
      if (way_age[2*i +: 2] > oldest_age) begin
        oldest_age = way_age[2*i +: 2];
        oldest_idx = 2'(i);
      end
    end
    if (hit_found)        eval_sel = hit_idx;
    else if (empty_found) eval_sel = empty_idx;
    else                  eval_sel = oldest_idx;
    eval_age    = way_age[{eval_sel, 1'b0} +: 2];
    eval_onehot = 4'b0001 << eval_sel;
    eval_inc    = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      if ((2'(j) != eval_sel) && !way_empty[j] &&
          (!hit_found || (way_age[2*j +: 2] < eval_age))) begin
        eval_inc[j] = 1'b1;
      end
    end
    multi_hit = |(way_hit & (way_hit - 4'd1));
  end

  // Next-state and next-output computation for the transaction sequencer.
  always_comb begin
    state_d             = state_q;
    req_ready_d         = req_ready_q;
    write_d             = write_q;
    way_address_d       = way_address_q;
    way_write_data_d    = way_write_data_q;
    sel_way_d           = sel_way_q;
    sel_hit_d           = sel_hit_q;
    way_ready_d         = 4'b0000;
    way_try_read_d      = 4'b0000;
    way_try_write_d     = 4'b0000;
    way_reset_age_d     = 4'b0000;
    way_increment_age_d = 4'b0000;
    resp_valid_d        = resp_valid_q;
    resp_data_d         = resp_data_q;
    resp_hit_d          = resp_hit_q;
    resp_way_d          = resp_way_q;
    hit_count_d         = hit_count_q;
    miss_count_d        = miss_count_q;
    multi_hit_err_d     = multi_hit_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          way_address_d    = req_address;
          way_write_data_d = req_wdata;
          write_d          = req_write;
          req_ready_d      = 1'b0;
          state_d          = PROBE;
        end
      end
      PROBE: begin
        state_d = EVAL;
      end
      EVAL: begin
        sel_way_d           = eval_sel;
        sel_hit_d           = hit_found;
        way_ready_d         = eval_onehot;
        way_try_read_d      = write_q ? 4'b0000 : eval_onehot;
        way_try_write_d     = write_q ? eval_onehot : 4'b0000;
        way_reset_age_d     = eval_onehot;
        way_increment_age_d = eval_inc;
        if (multi_hit) multi_hit_err_d = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (sel_hit_q) begin
          if (hit_count_q != '1) hit_count_d = hit_count_q + COUNTER_WIDTH'(1);
        end else begin
          if (miss_count_q != '1) miss_count_d = miss_count_q + COUNTER_WIDTH'(1);
        end
        state_d = CAPTURE;
      end
      CAPTURE: begin
        resp_data_d  = way_data[{sel_way_q, 3'b000} +: 8];
        resp_hit_d   = sel_hit_q;
        resp_way_d   = sel_way_q;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
        state_d      = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q             <= IDLE;
      req_ready_q         <= 1'b1;
      write_q             <= 1'b0;
      way_address_q       <= '0;
      way_write_data_q    <= 8'd0;
      sel_way_q           <= 2'd0;
      sel_hit_q           <= 1'b0;
      way_ready_q         <= 4'b0000;
      way_try_read_q      <= 4'b0000;
      way_try_write_q     <= 4'b0000;
      way_reset_age_q     <= 4'b0000;
      way_increment_age_q <= 4'b0000;
      resp_valid_q        <= 1'b0;
      resp_data_q         <= 8'd0;
      resp_hit_q          <= 1'b0;
      resp_way_q          <= 2'd0;
      hit_count_q         <= '0;
      miss_count_q        <= '0;
      multi_hit_err_q     <= 1'b0;
    end else begin
      state_q             <= state_d;
      req_ready_q         <= req_ready_d;
      write_q             <= write_d;
      way_address_q       <= way_address_d;
      way_write_data_q    <= way_write_data_d;
      sel_way_q           <= sel_way_d;
      sel_hit_q           <= sel_hit_d;
      way_ready_q         <= way_ready_d;
      way_try_read_q      <= way_try_read_d;
      way_try_write_q     <= way_try_write_d;
      way_reset_age_q     <= way_reset_age_d;
      way_increment_age_q <= way_increment_age_d;
      resp_valid_q        <= resp_valid_d;
      resp_data_q         <= resp_data_d;
      resp_hit_q          <= resp_hit_d;
      resp_way_q          <= resp_way_d;
      hit_count_q         <= hit_count_d;
      miss_count_q        <= miss_count_d;
      multi_hit_err_q     <= multi_hit_err_d;
    end
  end

  assign req_ready         = req_ready_q;
  assign resp_valid        = resp_valid_q;
  assign resp_data         = resp_data_q;
  assign resp_hit          = resp_hit_q;
  assign resp_way          = resp_way_q;
  assign way_address       = way_address_q;
  assign way_write_data    = way_write_data_q;
  assign way_ready         = way_ready_q;
  assign way_try_read      = way_try_read_q;
  assign way_try_write     = way_try_write_q;
  assign way_reset_age     = way_reset_age_q;
  assign way_increment_age = way_increment_age_q;
  assign hit_count         = hit_count_q;
  assign miss_count        = miss_count_q;
  assign multi_hit_err     = multi_hit_err_q;

endmodule

// File: tb/tb_cache_set_controller.sv
// Testbench for cache_set_controller: four emulated cache ways react to the
// strobes, and an LRU-list reference model predicts way choice, age updates,
// returned data and statistics for directed and random requests.
module tb_cache_set_controller;

  localparam int AW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_address = '0;
  logic [7:0]    req_wdata = 8'd0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [7:0]    resp_data;
  logic          resp_hit;
  logic [1:0]    resp_way;
  logic [AW-1:0] way_address;
  logic [7:0]    way_write_data;
  logic [3:0]    way_ready, way_try_read, way_try_write, way_reset_age, way_increment_age;
  logic [3:0]    way_hit, way_empty;
  logic [7:0]    way_age;
  logic [31:0]   way_data;
  logic [CW-1:0] hit_count, miss_count;
  logic          multi_hit_err;

  int checks = 0;
  int errors = 0;

  cache_set_controller #(.ADDRESS_WORD_SIZE(AW), .COUNTER_WIDTH(CW)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_hit(resp_hit), .resp_way(resp_way),
    .way_address(way_address), .way_write_data(way_write_data),
    .way_ready(way_ready), .way_try_read(way_try_read), .way_try_write(way_try_write),
    .way_reset_age(way_reset_age), .way_increment_age(way_increment_age),
    .way_hit(way_hit), .way_empty(way_empty), .way_age(way_age), .way_data(way_data),
    .hit_count(hit_count), .miss_count(miss_count), .multi_hit_err(multi_hit_err)
  );

  always #5 clk = ~clk;

  // Byte a read miss pulls in from the next memory level.
  function automatic logic [7:0] backing(input logic [AW-1:0] a);
    return a[7:0] ^ a[23:16] ^ 8'h3C;
  endfunction

  // Emulated cache ways (environment, not reference).
  logic [AW-1:0] em_tag   [4] = '{default: '0};
  logic [7:0]    em_data  [4] = '{default: 8'd0};
  logic [1:0]    em_age   [4] = '{default: 2'd0};
  logic [3:0]    em_valid = 4'b0000;
  logic [3:0]    hit_r    = 4'b0000;
  logic          force_en = 1'b0;
  logic [3:0]    force_val = 4'b0000;

  always_comb begin
    way_hit = force_en ? force_val : hit_r;
    way_empty = ~em_valid;
    way_age = 8'd0;
    way_data = 32'd0;
    for (int i = 0; i < 4; i++) begin
      way_age[2*i +: 2]  = em_age[i];
      way_data[8*i +: 8] = em_data[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      hit_r[i] <= em_valid[i] && (em_tag[i] == way_address);
      if (way_ready[i]) begin
        em_valid[i] <= 1'b1;
        em_tag[i]   <= way_address;
        if (way_try_write[i])  em_data[i] <= way_write_data;
        else if (!way_hit[i])  em_data[i] <= backing(way_address);
      end
      if (way_reset_age[i])          em_age[i] <= 2'd0;
      else if (way_increment_age[i]) em_age[i] <= em_age[i] + 2'd1;
    end
  end

  // Reference model: per-way contents plus a most-recent-first list of ways.
  logic [AW-1:0] ref_tag   [4] = '{default: '0};
  logic [7:0]    ref_data  [4] = '{default: 8'd0};
  bit            ref_valid [4] = '{default: 1'b0};
  int            lru[$];
  int            exp_hits = 0;
  int            exp_misses = 0;

  function automatic int lru_pos(input int w);
    for (int k = 0; k < lru.size(); k++) if (lru[k] == w) return k;
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction with prediction, strobe, latency and response checks.
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                               input logic [7:0] wd, input int hold);
    int sel, lat, acc_cycles;
    bit hit, got;
    logic [3:0] inc, onehot;
    logic [7:0] edata;
    sel = -1;
    for (int i = 0; i < 4; i++) if (sel < 0 && ref_valid[i] && ref_tag[i] == addr) sel = i;
    hit = (sel >= 0);
    inc = 4'b0000;
    if (hit) begin
      for (int k = 0; k < lru.size(); k++) begin
        if (lru[k] == sel) break;
        inc[lru[k]] = 1'b1;
      end
    end else begin
      for (int i = 0; i < 4; i++) if (sel < 0 && !ref_valid[i]) sel = i;
      if (sel < 0) sel = lru[lru.size()-1];
      for (int k = 0; k < lru.size(); k++) if (lru[k] != sel) inc[lru[k]] = 1'b1;
    end
    onehot = 4'b0001 << sel;
    edata = wr ? wd : (hit ? ref_data[sel] : backing(addr));
    if (hit) exp_hits = (exp_hits < 65535) ? exp_hits + 1 : exp_hits;
    else     exp_misses = (exp_misses < 65535) ? exp_misses + 1 : exp_misses;

    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready) got = 1'b1;
    end
    checkOutput("req_ready_wait", 32'(got), 32'd1);
    if (!got) return;
    req_valid = 1'b1; req_write = wr; req_address = addr; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_address = $urandom; req_wdata = 8'($urandom); req_write = 1'($urandom);
    lat = 0; acc_cycles = 0; got = 1'b0;
    while (lat < 12 && !got) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (!resp_valid) resp_ready = 1'($urandom);
      if (way_ready != 4'b0000) begin
        acc_cycles++;
        checkOutput("way_ready", 32'(way_ready), 32'(onehot));
        checkOutput("way_try_read", 32'(way_try_read), wr ? 32'd0 : 32'(onehot));
        checkOutput("way_try_write", 32'(way_try_write), wr ? 32'(onehot) : 32'd0);
        checkOutput("way_reset_age", 32'(way_reset_age), 32'(onehot));
        checkOutput("way_increment_age", 32'(way_increment_age), 32'(inc));
      end
      if (resp_valid) got = 1'b1;
    end
    resp_ready = 1'b0;
    checkOutput("resp_latency", 32'(lat), 32'd4);
    checkOutput("access_cycles", 32'(acc_cycles), 32'd1);
    checkOutput("resp_hit", 32'(resp_hit), 32'(hit));
    checkOutput("resp_way", 32'(resp_way), 32'(sel));
    checkOutput("resp_data", 32'(resp_data), 32'(edata));
    checkOutput("hit_count", 32'(hit_count), 32'(exp_hits));
    checkOutput("miss_count", 32'(miss_count), 32'(exp_misses));
    checkOutput("multi_hit_err", 32'(multi_hit_err), 32'd0);
    checkOutput("way_address", way_address, addr);
    checkOutput("way_write_data", 32'(way_write_data), 32'(wd));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("hold_resp_valid", 32'(resp_valid), 32'd1);
      checkOutput("hold_resp_data", 32'(resp_data), 32'(edata));
      checkOutput("hold_resp_way", 32'(resp_way), 32'(sel));
      checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput("resp_valid_drop", 32'(resp_valid), 32'd0);
    checkOutput("req_ready_back", 32'(req_ready), 32'd1);

    ref_valid[sel] = 1'b1;
    ref_tag[sel]   = addr;
    ref_data[sel]  = edata;
    if (lru_pos(sel) >= 0) lru.delete(lru_pos(sel));
    lru.push_front(sel);
    for (int i = 0; i < 4; i++)
      if (ref_valid[i]) checkOutput($sformatf("age_way%0d", i), 32'(em_age[i]), 32'(lru_pos(i)));
  endtask

  initial begin
    logic [AW-1:0] pool [6];
    int lat;
    bit got;
    for (int k = 0; k < 6; k++) pool[k] = 32'h0100_0000 * (k + 1) + 32'h20 + k;

    #12;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_strobes", {12'd0, way_ready, way_try_read, way_try_write, way_reset_age, way_increment_age}, 32'd0);
    checkOutput("rst_counts", {hit_count, miss_count}, 32'd0);
    checkOutput("rst_way_address", way_address, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    $display("[TB] directed sequence");
    applyStimulus(1'b0, 32'h0000_0013, 8'h00, 0);
    applyStimulus(1'b1, 32'h1200_0005, 8'hA5, 0);
    applyStimulus(1'b0, 32'h1200_0005, 8'h00, 0);
    applyStimulus(1'b1, 32'h2000_0010, 8'h11, 1);
    applyStimulus(1'b1, 32'h3000_0020, 8'h22, 0);
    applyStimulus(1'b0, 32'h0000_0013, 8'h00, 0);
    applyStimulus(1'b1, 32'h4000_0000, 8'h44, 0);
    applyStimulus(1'b0, 32'h4000_0000, 8'h00, 5);

    $display("[TB] random sequence");
    for (int n = 0; n < 40; n++)
      applyStimulus(1'($urandom), pool[$urandom_range(0, 5)], 8'($urandom), $urandom_range(0, 3));

    $display("[TB] forced multi-hit and reset abort");
    force_en = 1'b1; force_val = 4'b0110;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_address = 32'h0000_0013;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      if (resp_valid) got = 1'b1;
    end
    checkOutput("forced_resp_seen", 32'(got), 32'd1);
    checkOutput("forced_resp_way", 32'(resp_way), 32'd1);
    checkOutput("forced_resp_hit", 32'(resp_hit), 32'd1);
    checkOutput("forced_multi_hit_err", 32'(multi_hit_err), 32'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_address = 32'h5555_0000; req_wdata = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (lat < 10 && way_ready == 4'b0000) begin
      @(negedge clk); lat++;
    end
    checkOutput("abort_in_access", 32'(way_ready), 32'b0010);
    #1 rst_b = 1'b0;
    #1;
    checkOutput("abort_strobes", {12'd0, way_ready, way_try_read, way_try_write, way_reset_age, way_increment_age}, 32'd0);
    checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
    checkOutput("abort_resp", {22'd0, resp_valid, resp_data, resp_hit}, 32'd0);
    checkOutput("abort_resp_way", 32'(resp_way), 32'd0);
    checkOutput("abort_way_bus", way_address | 32'(way_write_data), 32'd0);
    checkOutput("abort_counts", {hit_count, miss_count}, 32'd0);
    checkOutput("abort_multi_hit_err", 32'(multi_hit_err), 32'd0);
    force_en = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("post_reset_idle", {28'd0, way_ready}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_set_controller.md
Name: cache_set_controller

Overview:
- Sequencing controller for one 4-way set-associative cache set. It sits directly upstream of four cache_line instances.
- Accepts byte read/write requests over a valid/ready handshake, probes all ways, selects a hit, empty or LRU victim way, and issues a one-cycle access strobe to that way.
- Maintains the 2-bit age (LRU) ordering across the ways and returns the read/written byte over a response handshake.
- Keeps hit/miss statistics.

Parameters:
- ADDRESS_WORD_SIZE, 32, width of request address and shared way address bus.
- COUNTER_WIDTH, 16, width of the saturating hit/miss counters.

Ports:
- clk  input  1  clock, rising edge.
- rst_b  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request; high only in IDLE.
- req_write  input  1  1 = write, 0 = read.
- req_address  input  ADDRESS_WORD_SIZE  byte address.
- req_wdata  input  8  write byte.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts response.
- resp_data  output  8  byte returned by the selected way.
- resp_hit  output  1  1 = transaction was a hit.
- resp_way  output  2  index of the way that served the transaction.
- way_address  output  ADDRESS_WORD_SIZE  shared address to all ways; holds last latched request.
- way_write_data  output  8  shared write byte to all ways.
- way_ready  output  4  per-way access strobe.
- way_try_read  output  4  per-way read select.
- way_try_write  output  4  per-way write select.
- way_reset_age  output  4  per-way age clear.
- way_increment_age  output  4  per-way age increment.
- way_hit  input  4  per-way hit_miss.
- way_empty  input  4  per-way is_empty.
- way_age  input  8  per-way age; way i on bits [2i+1:2i].
- way_data  input  32  per-way data; way i on bits [8i+7:8i].
- hit_count  output  COUNTER_WIDTH  saturating hit counter.
- miss_count  output  COUNTER_WIDTH  saturating miss counter.
- multi_hit_err  output  1  sticky flag: more than one way hit.

Behaviour:
- Reset (rst_b low, async): state is IDLE.
  - req_ready = 1.
  - resp_valid, resp_data, resp_hit, resp_way = 0.
  - way_address, way_write_data = 0; all way_* strobes = 0.
  - Counters = 0; multi_hit_err = 0.
  - Reset mid-transaction aborts it. No strobe may be issued after reset is asserted.
- FSM states: IDLE, PROBE, EVAL, ACCESS, CAPTURE, RESP.
- IDLE:
  - req_ready = 1.
  - If req_valid is high at an edge: latch req_address into way_address, req_wdata into way_write_data, and req_write internally; go to PROBE.
- PROBE: one cycle. The address is stable so the ways register hit_miss on this edge. Go to EVAL.
- EVAL: sample way_hit, way_empty and way_age, then register the selected way, the hit flag and sel_age.
  - Selection priority 1: lowest-index hitting way.
  - Priority 2: lowest-index empty way.
  - Priority 3: lowest-index way with the largest age.
  - If more than one bit of way_hit is set, set multi_hit_err (sticky until reset) and still use the lowest-index hit.
  - Go to ACCESS.
- ACCESS: exactly one cycle.
  - way_ready[sel] = 1.
  - way_try_read[sel] = ~write; way_try_write[sel] = write.
  - way_reset_age[sel] = 1.
  - On a hit: way_increment_age[j] = 1 for every non-empty j != sel with age_j < sel_age.
  - On a miss: way_increment_age[j] = 1 for every non-empty j != sel.
  - way_reset_age and way_increment_age are never both set for the same way.
  - Increment hit_count or miss_count; both saturate at all-ones, with no wrap.
  - Go to CAPTURE.
- CAPTURE: register way_data[8*sel+:8] into resp_data, and also resp_hit and resp_way. Go to RESP.
- RESP:
  - resp_valid = 1; resp_data, resp_hit and resp_way are held stable.
  - When resp_ready is high at an edge: resp_valid drops and the FSM goes to IDLE.
- Latency: resp_valid rises 4 edges after the acceptance edge. Back-to-back throughput is one request per 6 cycles minimum.
- Signals outside ACCESS: all way_ready, way_try_*, and way_*_age strobes are 0.
- Address bus: way_address and way_write_data change only on request acceptance.
- Simultaneous events: a req_valid arriving while not in IDLE is ignored (req_ready = 0). resp_ready outside RESP has no effect.
- Age invariant: the ages of the non-empty ways remain a permutation of 0..(n-1), where n is the number of non-empty ways.

Test Plan:
1. All ways empty; read address 0x0000_0013 → way 0 selected. resp_hit = 0, resp_way = 0, miss_count = 1. resp_valid rises 4 edges after acceptance.
2. Write 0xA5 to 0x1200_0005 → miss, fills way 1. Then read 0x1200_0005 → resp_hit = 1, resp_way = 1, resp_data = 0xA5, hit_count = 1.
3. Fill all 4 ways with distinct tags, then hit way 0 → way_increment_age asserted only for ways with age < way0's age. Way 0 age becomes 0.
4. Full set, new tag → way with age 3 selected. During ACCESS, way_increment_age = 1 for the other three ways and way_reset_age = 1 for the victim only.
5. Hold resp_ready = 0 for 5 cycles → resp_valid, resp_data and resp_way are stable and req_ready = 0. Then resp_ready = 1 → IDLE next cycle.
6. Force way_hit = 4'b0110 → resp_way = 1 and multi_hit_err = 1. Assert rst_b low during ACCESS → strobes drop immediately and all outputs return to their reset values.
